instr_decode_stage: RTL
=======================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2: output buffer entries, power of two, 2..16.
REQ-002 SHALL have parameter IMM_W, default 16: immediate output width, 8..32.
REQ-003 SHALL have parameter SIGN_EXT, default 1: 1 = sign-extend 8-bit immediates, 0 = zero-extend.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid  input  1  raw_instruction is valid.
REQ-008 SHALL have port in_ready  output  1  stage accepts an instruction this cycle.
REQ-009 SHALL have port raw_instruction  input  16  fetched instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry is valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 SHALL have ports opcode (8), rdst (4), rsrc (4), immediate (IMM_W) and flag_type (4), all outputs: decoded fields of the head entry.
REQ-013 SHALL have port illegal  output  1  head entry holds an unrecognised encoding.

Function
REQ-014 SHALL accept an instruction when in_valid && in_ready, with in_ready = (count < DEPTH) and no dependency on out_ready.
REQ-015 SHALL decode at acceptance and store {opcode, rdst, rsrc, immediate, flag_type, illegal} in a DEPTH-entry circular FIFO (write pointer, read pointer, count).
REQ-016 SHALL decode R-type for opcode [15:8] in {01,02,03,04,05,06,07,08,09,0B,0C,0F,84} hex: rdst=[7:4], rsrc=[3:0], immediate=0, flag_type=0001.
REQ-017 SHALL decode I-type for [15:12] in {1,2,3,5,9,B,D} hex: opcode={[15:12],0000}, rdst=[11:8], rsrc=0, immediate=extend([7:0]), flag_type=0010.
REQ-018 SHALL decode load/store for opcode 40 (LOAD) or 44 (STOR): rdst=[7:4], rsrc=[3:0] (address register), immediate=0, flag_type=0100.
REQ-019 SHALL decode jump for opcode 4C (Jcond: rdst=cond [7:4], rsrc=target [3:0], immediate=0) or [15:12]=C (Bcond: opcode=C0, rdst=cond [11:8], rsrc=0, immediate=extend([7:0])); both SHALL use flag_type=1000.
REQ-020 SHALL treat any other encoding as illegal: opcode=[15:8], rdst=0, rsrc=0, immediate=0, flag_type=0000, illegal=1; flag_type SHALL be exactly one-hot for every legal encoding.
REQ-021 SHALL sign- or zero-extend the 8-bit immediate to IMM_W per SIGN_EXT; no field SHALL ever be X.
REQ-022 SHALL present the head entry with 1-cycle latency: an instruction accepted at edge N into an empty buffer appears with out_valid=1 after edge N.
REQ-023 SHALL assert out_valid = (count != 0) and pop the head when out_valid && out_ready.
REQ-024 SHALL drive all data outputs and illegal to zero while out_valid=0.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; a pop from a full buffer SHALL raise in_ready on the following cycle only.
REQ-026 SHALL wrap both pointers modulo DEPTH.
REQ-027 SHALL treat flush as having priority over push and pop in the same cycle: the next state is empty and the input word is not accepted.
REQ-028 SHALL hold in_ready=0 in the flush cycle.
REQ-029 SHALL keep the head entry stable while out_valid && !out_ready.

Reset
REQ-030 SHALL, on reset assertion and regardless of clk, immediately set count=0, pointers=0, out_valid=0, all outputs 0, and in_ready=0.
REQ-031 SHALL set in_ready=1 on the first clk edge after reset deassertion.
REQ-032 SHALL discard any entries buffered when reset asserts mid-operation; none SHALL reappear after deassertion.

Verification
REQ-033 SHALL cover: raw 0x0512 then out_ready=1 -> opcode 05, rdst 1, rsrc 2, immediate 0, flag_type 0001, illegal 0, one cycle after acceptance.
REQ-034 SHALL cover: raw 0x53F0 with SIGN_EXT=1, IMM_W=16 -> opcode 50, rdst 3, immediate FFF0, flag_type 0010; with SIGN_EXT=0 -> immediate 00F0.
REQ-035 SHALL cover: raw 0xE123 -> illegal 1, flag_type 0000, opcode E1; raw 0x4C2A -> flag_type 1000, rdst 2, rsrc A.
REQ-036 SHALL cover: DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready low after the second; then out_ready=1 -> entries drain in order, and the third is accepted one cycle after the first pop.
REQ-037 SHALL cover: buffer holding 2 entries, flush=1 together with in_valid=1 -> next cycle out_valid 0, count 0, the input word is never output.
REQ-038 SHALL cover: reset asserted between edges with 1 entry buffered -> out_valid falls immediately, and out_valid stays 0 after release until a new push.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: decodes a 16-bit instruction word at acceptance
// and buffers the decoded fields in a small circular FIFO toward the consumer.
module instr_decode_stage #(
   parameter int DEPTH    = 2,
   parameter int IMM_W    = 16,
   parameter int SIGN_EXT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      raw_instruction,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       opcode,
   output logic [3:0]       rdst,
   output logic [3:0]       rsrc,
   output logic [IMM_W-1:0] immediate,
   output logic [3:0]       flag_type,
   output logic             illegal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [7:0]       opcode;
      logic [3:0]       rdst;
      logic [3:0]       rsrc;
      logic [IMM_W-1:0] imm;
      logic [3:0]       flag_type;
      logic             illegal;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           dec;
   entry_t           head;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rdy_q;
   logic             push;
   logic             pop;
   logic [IMM_W-1:0] imm_ext;

   assign imm_ext = (SIGN_EXT != 0) ? IMM_W'($signed(raw_instruction[7:0]))
                                    : IMM_W'(raw_instruction[7:0]);

   // Decode the incoming word; anything unmatched falls through as illegal.
   always_comb begin
      dec         = '0;
      dec.opcode  = raw_instruction[15:8];
      dec.illegal = 1'b1;
      if (raw_instruction[15:8] inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                        8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84}) begin
         dec.rdst      = raw_instruction[7:4];
         dec.rsrc      = raw_instruction[3:0];
         dec.flag_type = 4'b0001;
         dec.illegal   = 1'b0;
      end else if (raw_instruction[15:12] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
         dec.opcode    = {raw_instruction[15:12], 4'h0};
         dec.rdst      = raw_instruction[11:8];
         dec.imm       = imm_ext;
         dec.flag_type = 4'b0010;
         dec.illegal   = 1'b0;
      end else if (raw_instruction[15:8] == 8'h40 || raw_instruction[15:8] == 8'h44) begin
         dec.rdst      = raw_instruction[7:4];
         dec.rsrc      = raw_instruction[3:0];
         dec.flag_type = 4'b0100;
         dec.illegal   = 1'b0;
      end else if (raw_instruction[15:8] == 8'h4C) begin
         dec.rdst      = raw_instruction[7:4];
         dec.rsrc      = raw_instruction[3:0];
         dec.flag_type = 4'b1000;
         dec.illegal   = 1'b0;
      end else if (raw_instruction[15:12] == 4'hC) begin
         dec.opcode    = 8'hC0;
         dec.rdst      = raw_instruction[11:8];
         dec.imm       = imm_ext;
         dec.flag_type = 4'b1000;
         dec.illegal   = 1'b0;
      end
   end

   // Handshake: rdy_q keeps in_ready low until the first edge after reset.
   assign in_ready  = rdy_q && (count_q != CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // FIFO pointer/count next state; flush empties the buffer outright.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers and entry storage, cleared asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdy_q    <= 1'b1;
         if (push) mem_q[wr_ptr_q] <= dec;
      end
   end

   // Head entry presented only while valid; zeros otherwise.
   always_comb begin
      head = mem_q[rd_ptr_q];
      if (!out_valid) head = '0;
   end

   assign opcode    = head.opcode;
   assign rdst      = head.rdst;
   assign rsrc      = head.rsrc;
   assign immediate = head.imm;
   assign flag_type = head.flag_type;
   assign illegal   = head.illegal;

endmodule
